// File: rtl/adder_share_arb.sv
// Two-requester round-robin arbiter feeding one shared WIDTH-bit adder, with a
// single-entry registered result stage. Define ADDER_SHARE_ARB_SAT_EN for saturating sums.
module adder_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             r0_valid,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             id_q, id_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             xfer;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  // Grant depends only on valids and the pointer, never on operand values.
  always_comb begin
    can_accept = ena & ~rst & ((state_q == EMPTY) | res_ready);
    grant0     = r0_valid & (~r1_valid | last_q);
    grant1     = r1_valid & (~r0_valid | ~last_q);
    r0_ready   = can_accept & grant0;
    r1_ready   = can_accept & grant1;
    xfer       = (r0_valid & r0_ready) | (r1_valid & r1_ready);
  end

  always_comb begin
    op_a     = grant1 ? r1_a : r0_a;
    op_b     = grant1 ? r1_b : r0_b;
    full_sum = {1'b0, op_a} + {1'b0, op_b};
`ifdef ADDER_SHARE_ARB_SAT_EN
    add_carry = full_sum[WIDTH];
    add_sum   = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
    add_carry = full_sum[WIDTH];
    add_sum   = full_sum[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (res_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // A drain without a new transfer leaves the payload registers untouched.
    if (xfer) begin
      sum_d   = add_sum;
      carry_d = add_carry;
      id_d    = grant1;
      last_d  = grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign res_id    = id_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Table-driven bench for adder_share_arb: one row per clock cycle, readies and
// visible result checked mid-cycle, followed by a fairness run.
module tb_adder_share_arb;
  localparam int WIDTH = 8;

`ifdef ADDER_SHARE_ARB_SAT_EN
  localparam logic [7:0] OVF1_SUM = 8'hFF;
  localparam logic [7:0] OVF2_SUM = 8'hFF;
`else
  localparam logic [7:0] OVF1_SUM = 8'h00;
  localparam logic [7:0] OVF2_SUM = 8'hFE;
`endif

  logic             clk = 1'b0;
  logic             rst, ena, r0_valid, r1_valid, res_ready;
  logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
  logic             r0_ready, r1_ready, res_valid, res_id, res_carry;
  logic [WIDTH-1:0] res_sum;

  always #5 clk = ~clk;

  adder_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_carry(res_carry)
  );

  typedef struct {
    logic       rst, ena, v0;
    logic [7:0] a0, b0;
    logic       v1;
    logic [7:0] a1, b1;
    logic       rr;
    logic       e_r0r, e_r1r, e_rv, e_id;
    logic [7:0] e_sum;
    logic       e_c;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rs, logic en, logic v0, logic [7:0] a0, logic [7:0] b0,
                              logic v1, logic [7:0] a1, logic [7:0] b1, logic rr,
                              logic er0, logic er1, logic erv, logic eid,
                              logic [7:0] esum, logic ec);
    vec_t v;
    v.rst = rs; v.ena = en; v.v0 = v0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_r0r = er0; v.e_r1r = er1; v.e_rv = erv; v.e_id = eid;
    v.e_sum = esum; v.e_c = ec;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //            rst ena v0 a0    b0    v1 a1    b1    rr  r0r r1r rv id sum    c
    vecs[0]  = mk(1, 1, 1, 8'h02, 8'h03, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    vecs[1]  = mk(1, 1, 1, 8'h02, 8'h03, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 1, 1, 8'h02, 8'h03, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 8'h00, 0);
    vecs[3]  = mk(0, 1, 0, 8'h00, 8'h00, 1, 8'h20, 8'h02, 1, 0, 1, 1, 0, 8'h05, 0);
    vecs[4]  = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 1, 0, 1, 1, 8'h22, 0);
    vecs[5]  = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 0, 1, 1, 0, 8'h11, 0);
    vecs[6]  = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 1, 0, 1, 1, 8'h22, 0);
    vecs[7]  = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 0, 1, 1, 0, 8'h11, 0);
    vecs[8]  = mk(0, 1, 0, 8'h00, 8'h00, 1, 8'h40, 8'h04, 1, 0, 1, 1, 1, 8'h22, 0);
    vecs[9]  = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h40, 8'h04, 0, 0, 0, 1, 1, 8'h44, 0);
    vecs[10] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h40, 8'h04, 0, 0, 0, 1, 1, 8'h44, 0);
    vecs[11] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h40, 8'h04, 0, 0, 0, 1, 1, 8'h44, 0);
    vecs[12] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h40, 8'h04, 1, 1, 0, 1, 1, 8'h44, 0);
    vecs[13] = mk(0, 1, 1, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'h11, 0);
    vecs[14] = mk(0, 1, 1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, OVF1_SUM, 1);
    vecs[15] = mk(0, 1, 0, 8'h00, 8'h00, 1, 8'h7F, 8'h80, 1, 0, 1, 1, 0, OVF2_SUM, 1);
    vecs[16] = mk(0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'hFF, 0);
    vecs[17] = mk(0, 0, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 0, 0, 1, 0, 8'h00, 0);
    vecs[18] = mk(0, 0, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 0, 0, 1, 0, 8'h00, 0);
    vecs[19] = mk(0, 0, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 0, 0, 0, 0, 8'h00, 0);
    vecs[20] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 1, 0, 1, 0, 0, 8'h00, 0);
    vecs[21] = mk(0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'h22, 0);
    vecs[22] = mk(1, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 0, 0, 1, 1, 8'h22, 0);
    vecs[23] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 1, 0, 0, 0, 8'h00, 0);
    vecs[24] = mk(0, 1, 1, 8'h10, 8'h01, 1, 8'h20, 8'h02, 0, 0, 0, 1, 0, 8'h11, 0);

    rst = 1'b1; ena = 1'b1; res_ready = 1'b0;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      #1;
      rst = vecs[i].rst; ena = vecs[i].ena; res_ready = vecs[i].rr;
      r0_valid = vecs[i].v0; r0_a = vecs[i].a0; r0_b = vecs[i].b0;
      r1_valid = vecs[i].v1; r1_a = vecs[i].a1; r1_b = vecs[i].b1;
      @(negedge clk);
      $display("step %0d: r0_ready=%0b r1_ready=%0b res_valid=%0b id=%0b sum=%02h carry=%0b",
               i, r0_ready, r1_ready, res_valid, res_id, res_sum, res_carry);
      check("r0_ready",  i, 32'(r0_ready),  32'(vecs[i].e_r0r));
      check("r1_ready",  i, 32'(r1_ready),  32'(vecs[i].e_r1r));
      check("res_valid", i, 32'(res_valid), 32'(vecs[i].e_rv));
      check("res_id",    i, 32'(res_id),    32'(vecs[i].e_id));
      check("res_sum",   i, 32'(res_sum),   32'(vecs[i].e_sum));
      check("res_carry", i, 32'(res_carry), 32'(vecs[i].e_c));
      @(posedge clk);
    end

    // Fairness: both requesters valid and consumer always ready.
    begin
      logic exp_g, prev_g;
      exp_g  = 1'b1;
      prev_g = 1'b0;
      for (int k = 0; k < 8; k++) begin
        #1;
        rst = 1'b0; ena = 1'b1; res_ready = 1'b1;
        r0_valid = 1'b1; r0_a = 8'h10; r0_b = 8'h01;
        r1_valid = 1'b1; r1_a = 8'h20; r1_b = 8'h02;
        @(negedge clk);
        $display("fair %0d: r0_ready=%0b r1_ready=%0b res_id=%0b sum=%02h",
                 k, r0_ready, r1_ready, res_id, res_sum);
        check("fair_r0_ready", k, 32'(r0_ready), 32'(!exp_g));
        check("fair_r1_ready", k, 32'(r1_ready), 32'(exp_g));
        check("fair_res_valid", k, 32'(res_valid), 32'd1);
        check("fair_res_id", k, 32'(res_id), 32'(prev_g));
        check("fair_res_sum", k, 32'(res_sum), prev_g ? 32'h22 : 32'h11);
        @(posedge clk);
        prev_g = exp_g;
        exp_g  = !exp_g;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
